// File: rtl/spi_master_crc.sv
// -----------------------------------------------------------------------------
// spi_master_crc
//
// SPI master (mode 0: sck idle low, data launched on sck rising, sampled on sck
// falling) moving one fixed 32-bit frame per request: a 24-bit payload, MSB
// first, followed by an 8-bit CRC, MSB first. The CRC is CRC-8, polynomial
// 0x1D, initial value 0xFF, no final XOR, computed bit-serially over the
// payload. The same CRC is computed locally over the received payload and
// compared against the 8 CRC bits returned by the slave.
//
// Optional feature macro: SPI_MASTER_CRC_CHECK_EN
//   defined   : CRC is generated on bits 24-31 and checked on receive.
//   undefined : bits 24-31 carry 0x00, received CRC bits are dropped and
//               crc_err stays 0. Frame length and timing are identical.
//
// Parameters
//   CLK_DIV   sck half-period in clk cycles (>= 1)
//   CS_SETUP  clk cycles from csn low to the start of the first sck low phase
//   CS_HOLD   clk cycles from the last sck falling edge to csn high
//
// Ports
//   clk      in   system clock, all logic on its rising edge
//   rst      in   asynchronous active-high reset
//   start    in   single-cycle frame request, accepted only while idle
//   tx_data  in   24-bit payload to send
//   busy     out  high while a frame is in progress (low again in the done cycle)
//   done     out  one-cycle pulse at the end of a frame
//   rx_data  out  24-bit payload received, updated only in the done cycle
//   crc_err  out  received CRC differs from local CRC, updated only in the done cycle
//   sck      out  SPI clock, idle low
//   csn      out  chip select, active low
//   mosi     out  master data out
//   miso     in   slave data in
// -----------------------------------------------------------------------------
module spi_master_crc #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic [23:0] rx_data,
  output logic        crc_err,
  output logic        sck,
  output logic        csn,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Phase counter values inside one bit period: the cycle at HALF_LAST is the
  // last low cycle (sck rises at its end), PER_LAST the last high cycle.
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] PER_LAST  = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] SETUP_CYC = 16'(CS_SETUP);
  localparam logic [15:0] HOLD_CYC  = 16'(CS_HOLD);
  localparam logic [4:0]  PAY_BITS  = 5'd24;
  localparam logic [4:0]  LAST_BIT  = 5'd31;

`ifdef SPI_MASTER_CRC_CHECK_EN
  // One bit-serial CRC-8 step, polynomial 0x1D.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    crc8_step = {crc[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
  endfunction
`endif

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [4:0]  bit_cnt_r, bit_cnt_s;
  logic [23:0] tx_sh_r, tx_sh_s;
  logic [23:0] rx_sh_r, rx_sh_s;
  logic        sck_r, sck_s;
  logic        csn_r, csn_s;
  logic        mosi_r, mosi_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [23:0] rx_data_r, rx_data_s;
  logic        crc_err_r, crc_err_s;
`ifdef SPI_MASTER_CRC_CHECK_EN
  logic [7:0]  tx_crc_r, tx_crc_s;   // CRC being generated, then shifted out
  logic [7:0]  rx_crc_r, rx_crc_s;   // CRC computed locally over received payload
  logic [7:0]  rx_rcv_r, rx_rcv_s;   // CRC bits returned by the slave
`endif

  assign sck     = sck_r;
  assign csn     = csn_r;
  assign mosi    = mosi_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign rx_data = rx_data_r;
  assign crc_err = crc_err_r;

  // Next-state and next-register logic for the frame sequencer.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_cnt_s = bit_cnt_r;
    tx_sh_s   = tx_sh_r;
    rx_sh_s   = rx_sh_r;
    sck_s     = sck_r;
    csn_s     = csn_r;
    mosi_s    = mosi_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    rx_data_s = rx_data_r;
    crc_err_s = crc_err_r;
`ifdef SPI_MASTER_CRC_CHECK_EN
    tx_crc_s  = tx_crc_r;
    rx_crc_s  = rx_crc_r;
    rx_rcv_s  = rx_rcv_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s   = ST_SETUP;
          cnt_s     = 16'd0;
          bit_cnt_s = 5'd0;
          tx_sh_s   = tx_data;
          sck_s     = 1'b0;
          csn_s     = 1'b0;
          busy_s    = 1'b1;
`ifdef SPI_MASTER_CRC_CHECK_EN
          tx_crc_s  = 8'hFF;
          rx_crc_s  = 8'hFF;
          rx_rcv_s  = 8'h00;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if ((cnt_r + 16'd1) >= SETUP_CYC) begin
          state_s = ST_XFER;
          cnt_s   = 16'd0;
          sck_s   = 1'b0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_XFER: begin
        if (cnt_r == HALF_LAST) begin
          // Rising edge: launch the next bit.
          sck_s = 1'b1;
          cnt_s = cnt_r + 16'd1;
          if (bit_cnt_r < PAY_BITS) begin
            mosi_s  = tx_sh_r[23];
            tx_sh_s = {tx_sh_r[22:0], 1'b0};
`ifdef SPI_MASTER_CRC_CHECK_EN
            tx_crc_s = crc8_step(tx_crc_r, tx_sh_r[23]);
`endif
          end else begin
`ifdef SPI_MASTER_CRC_CHECK_EN
            mosi_s   = tx_crc_r[7];
            tx_crc_s = {tx_crc_r[6:0], 1'b0};
`else
            mosi_s   = 1'b0;
`endif
          end
        end else if (cnt_r == PER_LAST) begin
          // Falling edge: capture miso, advance to the next bit or finish.
          sck_s = 1'b0;
          cnt_s = 16'd0;
          if (bit_cnt_r < PAY_BITS) begin
            rx_sh_s = {rx_sh_r[22:0], miso};
`ifdef SPI_MASTER_CRC_CHECK_EN
            rx_crc_s = crc8_step(rx_crc_r, miso);
`endif
          end else begin
`ifdef SPI_MASTER_CRC_CHECK_EN
            rx_rcv_s = {rx_rcv_r[6:0], miso};
`else
            rx_sh_s  = rx_sh_r;
`endif
          end
          if (bit_cnt_r == LAST_BIT) begin
            state_s = ST_HOLD;
          end else begin
            bit_cnt_s = bit_cnt_r + 5'd1;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_HOLD: begin
        if ((cnt_r + 16'd1) >= HOLD_CYC) begin
          state_s   = ST_DONE;
          cnt_s     = 16'd0;
          bit_cnt_s = 5'd0;
          csn_s     = 1'b1;
          busy_s    = 1'b0;
          done_s    = 1'b1;
          rx_data_s = rx_sh_r;
`ifdef SPI_MASTER_CRC_CHECK_EN
          crc_err_s = (rx_rcv_r != rx_crc_r);
`else
          crc_err_s = 1'b0;
`endif
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_DONE: begin
        // start seen here is deliberately dropped; idle accepts it next cycle.
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        sck_s   = 1'b0;
        csn_s   = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= 16'd0;
      bit_cnt_r <= 5'd0;
      tx_sh_r   <= 24'd0;
      rx_sh_r   <= 24'd0;
      sck_r     <= 1'b0;
      csn_r     <= 1'b1;
      mosi_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rx_data_r <= 24'd0;
      crc_err_r <= 1'b0;
`ifdef SPI_MASTER_CRC_CHECK_EN
      tx_crc_r  <= 8'hFF;
      rx_crc_r  <= 8'hFF;
      rx_rcv_r  <= 8'h00;
`endif
    end else begin
      cnt_r     <= cnt_s;
      bit_cnt_r <= bit_cnt_s;
      tx_sh_r   <= tx_sh_s;
      rx_sh_r   <= rx_sh_s;
      sck_r     <= sck_s;
      csn_r     <= csn_s;
      mosi_r    <= mosi_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      rx_data_r <= rx_data_s;
      crc_err_r <= crc_err_s;
`ifdef SPI_MASTER_CRC_CHECK_EN
      tx_crc_r  <= tx_crc_s;
      rx_crc_r  <= rx_crc_s;
      rx_rcv_r  <= rx_rcv_s;
`endif
    end
  end

endmodule

// File: tb/tb_spi_master_crc.sv
// -----------------------------------------------------------------------------
// tb_spi_master_crc
//
// Directed bench for spi_master_crc with default parameters (CLK_DIV=4,
// CS_SETUP=2, CS_HOLD=2). A negedge-clocked slave model returns a 32-bit word
// on miso, captures the mosi frame, counts sck pulses and done pulses, and
// watches that mosi/miso do not move between an sck rising and falling edge.
// Expected CRC bytes follow SPI_MASTER_CRC_CHECK_EN the same way the DUT does.
// -----------------------------------------------------------------------------
module tb_spi_master_crc;

`ifdef SPI_MASTER_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] tx_data;
  logic        busy;
  logic        done;
  logic [23:0] rx_data;
  logic        crc_err;
  logic        sck;
  logic        csn;
  logic        mosi;
  logic        miso;

  int total = 0;
  int bad   = 0;

  // Slave model / monitor state
  logic        mon_clr;
  logic [31:0] slv_word;
  logic        sck_q;
  int          rise_cnt;
  int          done_cnt;
  int          stab_err;
  int          csn_err;
  int          slv_idx;
  logic [31:0] mosi_frame;
  logic        mosi_at_rise;
  logic        miso_at_rise;

  logic [23:0] last_rx;
  logic        last_err;

  spi_master_crc dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .crc_err (crc_err),
    .sck     (sck),
    .csn     (csn),
    .mosi    (mosi),
    .miso    (miso)
  );

  always #5 clk = ~clk;

  // Reference CRC-8 (poly 0x1D, init 0xFF) over a 24-bit payload, MSB first.
  function automatic logic [7:0] crc_model(input logic [23:0] d);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 23; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h1D;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Slave model and bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_clr) begin
      sck_q        <= 1'b0;
      rise_cnt     <= 0;
      done_cnt     <= 0;
      stab_err     <= 0;
      csn_err      <= 0;
      slv_idx      <= 0;
      mosi_frame   <= 32'h0;
      mosi_at_rise <= 1'b0;
      miso_at_rise <= 1'b0;
      miso         <= 1'b0;
    end else begin
      sck_q <= sck;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (sck === 1'b1 && sck_q === 1'b0) begin
        rise_cnt     <= rise_cnt + 1;
        mosi_frame   <= {mosi_frame[30:0], mosi};
        mosi_at_rise <= mosi;
        if (csn !== 1'b0) csn_err <= csn_err + 1;
        if (slv_idx < 32) begin
          miso         <= slv_word[31 - slv_idx];
          miso_at_rise <= slv_word[31 - slv_idx];
        end
        slv_idx <= slv_idx + 1;
      end
      if (sck === 1'b0 && sck_q === 1'b1) begin
        if (mosi !== mosi_at_rise || miso !== miso_at_rise) stab_err <= stab_err + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete frame with checks. With prestarted set, start is already high
  // in an idle cycle (left there by the previous call's chain_next).
  task automatic do_frame(input string name, input logic [23:0] tx, input logic [31:0] slv,
                          input logic [23:0] exp_rx, input logic exp_err,
                          input bit prestarted, input bit xfer_repulse,
                          input bit chain_next, input logic [23:0] next_tx);
    int n;
    logic [7:0] exp_crc;
    exp_crc  = CRC_ON ? crc_model(tx) : 8'h00;
    slv_word = slv;
    if (prestarted) begin
      #1 mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
      start = 1'b0;
    end else begin
      @(negedge clk);
      #1 mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
      tx_data = tx;
      start   = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
    end
    // First cycle after accept
    chk({name, "_busy_early"}, busy, 32'd1);
    chk({name, "_csn_low"}, csn, 32'd0);
    chk({name, "_rx_hold_early"}, rx_data, last_rx);
    chk({name, "_err_hold_early"}, crc_err, last_err);
    n = 1;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (xfer_repulse) start = (n == 100);
      if (n == 260) chk({name, "_rx_hold_late"}, rx_data, last_rx);
    end
    chk({name, "_latency"}, 32'(n), 32'd261);
    chk({name, "_done"}, done, 32'd1);
    chk({name, "_rx_data"}, rx_data, exp_rx);
    chk({name, "_crc_err"}, crc_err, exp_err);
    chk({name, "_busy_done"}, busy, 32'd0);
    chk({name, "_csn_done"}, csn, 32'd1);
    if (chain_next) begin
      start   = 1'b1;
      tx_data = next_tx;
    end
    @(negedge clk);
    chk({name, "_done_pulse"}, done, 32'd0);
    chk({name, "_busy_idle"}, busy, 32'd0);
    chk({name, "_rx_keep"}, rx_data, exp_rx);
    #1;
    chk({name, "_sck_pulses"}, 32'(rise_cnt), 32'd32);
    chk({name, "_mosi_frame"}, mosi_frame, {tx, exp_crc});
    chk({name, "_stable"}, 32'(stab_err), 32'd0);
    chk({name, "_csn_frame"}, 32'(csn_err), 32'd0);
    chk({name, "_done_count"}, 32'(done_cnt), 32'd1);
    last_rx  = exp_rx;
    last_err = exp_err;
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    tx_data  = 24'h0;
    slv_word = 32'h0;
    mon_clr  = 1'b1;
    last_rx  = 24'h0;
    last_err = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_sck", sck, 32'd0);
    chk("rst_csn", csn, 32'd1);
    chk("rst_mosi", mosi, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_rx_data", rx_data, 32'd0);
    chk("rst_crc_err", crc_err, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_clr = 1'b0;

    // Zero payload, correct CRC 0x0E returned
    do_frame("a", 24'h000000, {24'h000000, 8'h0E}, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    // Zero payload, corrupted CRC 0x0F returned
    do_frame("b", 24'h000000, {24'h000000, 8'h0F}, 24'h000000, CRC_ON, 1'b0, 1'b0, 1'b0, 24'h0);
    // Mixed payloads both directions, slave CRC from the model
    do_frame("c", 24'hA5A5A5, {24'hFEDCBA, crc_model(24'hFEDCBA)}, 24'hFEDCBA, 1'b0,
             1'b0, 1'b0, 1'b0, 24'h0);
    // start re-pulsed in XFER and in DONE; start in the following idle cycle chains
    do_frame("d", 24'h000000, {24'h000000, 8'h0E}, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b1, 24'h3C3C3C);
    do_frame("e", 24'h3C3C3C, {24'h000000, 8'h0E}, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);

    // Frame aborted by reset around bit 10
    slv_word = 32'h123456AB;
    @(negedge clk);
    #1 mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    tx_data = 24'hFFFFFF;
    start   = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    n = 0;
    while (rise_cnt < 10 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort_reach_bit10", 32'(rise_cnt), 32'd10);
    chk("abort_sck_high", sck, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_sck", sck, 32'd0);
    chk("abort_csn", csn, 32'd1);
    chk("abort_mosi", mosi, 32'd0);
    chk("abort_busy", busy, 32'd0);
    chk("abort_done", done, 32'd0);
    chk("abort_rx_data", rx_data, 32'h0);
    chk("abort_crc_err", crc_err, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_rx_keep", rx_data, 32'h0);
    chk("abort_idle_busy", busy, 32'd0);
    chk("abort_idle_csn", csn, 32'd1);

    // Clean frame after the abort
    do_frame("g", 24'h000000, {24'h000000, 8'h0E}, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_crc.md
SPI_MASTER_CRC -- requirements
Module: spi_master_crc

Interface
REQ-001 Parameter CLK_DIV, default 4, SCK half-period in clk cycles (legal values >=1).
REQ-002 Parameter CS_SETUP, default 2, clk cycles from csn falling to the first SCK rising edge window.
REQ-003 Parameter CS_HOLD, default 2, clk cycles from the last SCK falling edge to csn rising.
REQ-004 clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a frame.
REQ-007 tx_data  input  24  payload to transmit, MSB first.
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse when a frame completes.
REQ-010 rx_data  output  24  payload received from MISO.
REQ-011 crc_err  output  1  received CRC mismatch flag, valid when done is high and held until the next done.
REQ-012 sck  output  1  SPI clock, idle low.
REQ-013 csn  output  1  chip select, active low.
REQ-014 mosi  output  1  master data out.
REQ-015 miso  input  1  slave data in.

Function
REQ-016 Frame is 32 bits: 24 payload bits, MSB first, then 8 CRC bits, MSB first.
REQ-017 CRC is CRC-8 with polynomial 0x1D, initial value 0xFF and no final XOR, processed bit-serially over the 24 payload bits: crc = (crc<<1) ^ (crc[7]^bit ? 0x1D : 0).
REQ-018 States are IDLE, SETUP, XFER, HOLD and DONE.
REQ-019 IDLE: start=1 latches tx_data, clears the CRC register to 0xFF, drives csn low, goes to SETUP; start while not in IDLE is ignored.
REQ-020 SETUP: waits CS_SETUP cycles, then goes to XFER with sck low.
REQ-021 XFER bit period: sck low for CLK_DIV cycles, then high for CLK_DIV cycles; 32 periods, total 64*CLK_DIV cycles.
REQ-022 mosi changes only in the cycle sck rises; bit n is driven at the n-th rising edge and held through the n-th falling edge.
REQ-023 miso is sampled in the cycle sck falls; samples 0-23 shift into the rx register and samples 24-31 shift into the rx CRC register.
REQ-024 The TX CRC and a local RX CRC each update once per payload bit; the TX CRC is shifted out on bits 24-31.
REQ-025 After the 32nd falling edge the block goes to HOLD with sck low and mosi held at its last value.
REQ-026 HOLD: waits CS_HOLD cycles, drives csn high, goes to DONE.
REQ-027 DONE: for one cycle, done=1, rx_data is updated, crc_err = (received CRC != local RX CRC), busy=0; then returns to IDLE.
REQ-028 start asserted in the DONE cycle is ignored; start is accepted only in IDLE, the earliest being the cycle after done.
REQ-029 rx_data and crc_err do not change outside the DONE cycle.

Reset
REQ-030 On rst (asynchronous, mid-frame included) the state goes to IDLE and outputs take: sck=0, csn=1, mosi=0, busy=0, done=0, rx_data=0, crc_err=0, both CRC registers=0xFF, bit counter=0.
REQ-031 A frame aborted by reset produces no done pulse and leaves no partial rx_data update.

Configuration
REQ-032 Macro SPI_MASTER_CRC_CHECK_EN defined: CRC generation and checking operate as specified in REQ-017, REQ-024 and REQ-027.
REQ-033 Macro SPI_MASTER_CRC_CHECK_EN undefined: bits 24-31 of the frame transmit 0x00, received CRC bits are discarded, crc_err is constant 0, and frame length and timing are unchanged.

Verification
REQ-034 CLK_DIV=4, tx_data=0x000000, start -> mosi frame 0x0000000E, exactly 32 sck pulses, done asserted 2+256+2+1 cycles after the start-accept cycle.
REQ-035 Slave model returns 0x000000 with CRC 0x0E -> rx_data=0x000000, crc_err=0; same payload with CRC 0x0F -> crc_err=1.
REQ-036 Slave model returns 0xFEDCBA with the model-computed CRC -> rx_data=0xFEDCBA, crc_err=0; mosi and miso are stable across every sck falling edge.
REQ-037 rst pulsed at bit 10 of a frame -> sck=0 and csn=1 immediately, no done pulse, rx_data unchanged; a following start with tx_data=0x000000 yields a clean 0x0000000E frame.
REQ-038 start re-pulsed during XFER and in the DONE cycle -> ignored, one frame only; start in the cycle after done -> a new frame begins.
REQ-039 SPI_MASTER_CRC_CHECK_EN undefined, tx_data=0xA5A5A5 -> mosi frame 0xA5A5A500, crc_err=0 for any miso CRC.
